// File: rtl/mem_bist_ctrl.sv
// Built-in self-test controller for a single-port synchronous memory.
// Runs a two-pass (pattern, inverted pattern) write/read sweep and reports pass/fail and first-failure details.
module mem_bist_ctrl #(
    parameter int                ADDR_W  = 5,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W+1:0] err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_pass_sel;
    logic                r_pend_valid;
    logic [ADDR_W-1:0]   r_pend_addr;
    logic                r_read;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data_in;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic                r_fail;
    logic [ADDR_W+1:0]   r_err_count;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [DATA_W-1:0]   r_fail_exp;
    logic [DATA_W-1:0]   r_fail_act;

    logic [DATA_W-1:0]   w_exp;
    logic                w_mismatch;
    logic                w_last;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic [ADDR_W+1:0]   w_err_next;

    // Expected data: pass 0 uses PATTERN ^ address, pass 1 its complement.
    function automatic logic [DATA_W-1:0] exp_data(input logic p, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] e;
        e = PATTERN ^ DATA_W'(a);
        return p ? ~e : e;
    endfunction

    // Compare the read issued last cycle, whose data is on data_out now.
    always_comb begin
        w_exp      = exp_data(r_pass_sel, r_pend_addr);
        w_mismatch = r_pend_valid && (data_out != w_exp);
        w_last     = (r_addr == {ADDR_W{1'b1}});
        w_addr_inc = r_addr + ADDR_W'(1);
        w_err_next = r_err_count + (ADDR_W+2)'(w_mismatch);
    end

    // Test sequencer; every bus and status output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pass_sel   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_data_in    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_err_count  <= '0;
            r_fail_addr  <= '0;
            r_fail_exp   <= '0;
            r_fail_act   <= '0;
        end else if (abort && (r_state != ST_IDLE)) begin
            // Partial err_count and fail_* are deliberately kept for debug.
            r_state      <= ST_IDLE;
            r_pend_valid <= 1'b0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_pend_valid <= 1'b0;
            if (w_mismatch) begin
                r_err_count <= w_err_next;
                if (r_err_count == '0) begin
                    r_fail_addr <= r_pend_addr;
                    r_fail_exp  <= w_exp;
                    r_fail_act  <= data_out;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_addr  <= '0;
                    if (start) begin
                        r_state     <= ST_WR;
                        r_pass_sel  <= 1'b0;
                        r_write     <= 1'b1;
                        r_data_in   <= exp_data(1'b0, '0);
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_fail      <= 1'b0;
                        r_err_count <= '0;
                        r_fail_addr <= '0;
                        r_fail_exp  <= '0;
                        r_fail_act  <= '0;
                    end
                end
                ST_WR: begin
                    if (w_last) begin
                        r_state <= ST_RD;
                        r_write <= 1'b0;
                        r_read  <= 1'b1;
                        r_addr  <= '0;
                    end else begin
                        r_addr    <= w_addr_inc;
                        r_data_in <= exp_data(r_pass_sel, w_addr_inc);
                    end
                end
                ST_RD: begin
                    r_pend_valid <= 1'b1;
                    r_pend_addr  <= r_addr;
                    if (w_last) begin
                        r_state <= ST_DRAIN;
                        r_read  <= 1'b0;
                        r_addr  <= '0;
                    end else begin
                        r_addr <= w_addr_inc;
                    end
                end
                ST_DRAIN: begin
                    if (!r_pass_sel) begin
                        r_state    <= ST_WR;
                        r_pass_sel <= 1'b1;
                        r_write    <= 1'b1;
                        r_addr     <= '0;
                        r_data_in  <= exp_data(1'b1, '0);
                    end else begin
                        // Include the final read's result in the verdict.
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                        r_fail  <= (w_err_next != '0);
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign read      = r_read;
    assign write     = r_write;
    assign addr      = r_addr;
    assign data_in   = r_data_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign err_count = r_err_count;
    assign fail_addr = r_fail_addr;
    assign fail_exp  = r_fail_exp;
    assign fail_act  = r_fail_act;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: behavioural memory with injectable faults, a table of
// scenarios, a cycle-indexed bus reference and a result scoreboard popped on done.
module tb_mem_bist_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       read;
    logic       write;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fail;
    logic [6:0] err_count;
    logic [4:0] fail_addr;
    logic [7:0] fail_exp;
    logic [7:0] fail_act;

    int n_checks = 0;
    int n_errors = 0;
    int fault_mode = 0;

    logic [7:0] mem [32];
    logic [7:0] mem_q;

    typedef struct {
        int fault;
        int repulse;
        int abort_at;
        int rst_at;
        bit has_done;
        bit e_pass;
        bit e_fail;
        int e_err;
        int e_faddr;
        int e_fexp;
        int e_fact;
    } vec_t;

    vec_t tbl[7];
    vec_t sb[$];

    mem_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .PATTERN(8'h55)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .read(read), .write(write), .addr(addr), .data_in(data_in),
        .data_out(data_out), .busy(busy), .done(done), .pass(pass),
        .fail(fail), .err_count(err_count), .fail_addr(fail_addr),
        .fail_exp(fail_exp), .fail_act(fail_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Faulty memory: mode 1 sticks bit 0 of word 5 at 0, mode 2 sticks address bit 4 at 0.
    function automatic logic [4:0] phys(input logic [4:0] a);
        return (fault_mode == 2) ? (a & 5'h0F) : a;
    endfunction

    always @(posedge clk) begin
        if (write)
            mem[phys(addr)] <= (fault_mode == 1 && addr == 5'd5) ? (data_in & 8'hFE) : data_in;
        if (read)
            mem_q <= mem[phys(addr)];
    end
    assign data_out = mem_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".read"}, 32'(read), 32'd0);
        check({tag, ".write"}, 32'(write), 32'd0);
        check({tag, ".addr"}, 32'(addr), 32'd0);
        check({tag, ".data_in"}, 32'(data_in), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".pass"}, 32'(pass), 32'd0);
        check({tag, ".fail"}, 32'(fail), 32'd0);
        check({tag, ".err_count"}, 32'(err_count), 32'd0);
        check({tag, ".fail_addr"}, 32'(fail_addr), 32'd0);
        check({tag, ".fail_exp"}, 32'(fail_exp), 32'd0);
        check({tag, ".fail_act"}, 32'(fail_act), 32'd0);
    endtask

    // Reference bus behaviour indexed by cycle number after the start edge.
    task automatic check_cycle(input int k, input bit stopped);
        bit         e_busy, e_done, e_wr, e_rd;
        logic [4:0] a;
        logic [7:0] e_d;
        e_busy = !stopped && k >= 1 && k <= 130;
        e_done = !stopped && k == 131;
        e_wr   = !stopped && ((k >= 1 && k <= 32) || (k >= 66 && k <= 97));
        e_rd   = !stopped && ((k >= 33 && k <= 64) || (k >= 98 && k <= 129));
        if (k <= 32)      a = 5'(k - 1);
        else if (k <= 64) a = 5'(k - 33);
        else if (k <= 97) a = 5'(k - 66);
        else              a = 5'(k - 98);
        e_d = 8'h55 ^ {3'b000, a};
        if (k >= 66) e_d = ~e_d;
        check($sformatf("busy@%0d", k), 32'(busy), 32'(e_busy));
        check($sformatf("done@%0d", k), 32'(done), 32'(e_done));
        check($sformatf("write@%0d", k), 32'(write), 32'(e_wr));
        check($sformatf("read@%0d", k), 32'(read), 32'(e_rd));
        if (e_wr || e_rd)
            check($sformatf("addr@%0d", k), 32'(addr), 32'(a));
        else if (stopped || k == 132)
            check($sformatf("idle_addr@%0d", k), 32'(addr), 32'd0);
        if (e_wr)
            check($sformatf("data_in@%0d", k), 32'(data_in), 32'(e_d));
        if (stopped || k <= 130) begin
            check($sformatf("pass@%0d", k), 32'(pass), 32'd0);
            check($sformatf("fail@%0d", k), 32'(fail), 32'd0);
        end
    endtask

    task automatic compare_result(input string tag, input vec_t v);
        check({tag, ".pass"}, 32'(pass), 32'(v.e_pass));
        check({tag, ".fail"}, 32'(fail), 32'(v.e_fail));
        check({tag, ".err_count"}, 32'(err_count), 32'(v.e_err));
        check({tag, ".fail_addr"}, 32'(fail_addr), 32'(v.e_faddr));
        check({tag, ".fail_exp"}, 32'(fail_exp), 32'(v.e_fexp));
        check({tag, ".fail_act"}, 32'(fail_act), 32'(v.e_fact));
    endtask

    task automatic run_test(input int idx, input vec_t v);
        vec_t got;
        bit   stopped;
        fault_mode = v.fault;
        @(negedge clk);
        start = 1'b1;
        if (v.has_done) sb.push_back(v);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 132; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            stopped = (v.abort_at > 0 && k > v.abort_at) || (v.rst_at > 0 && k > v.rst_at);
            check_cycle(k, stopped);
            if (done === 1'b1) begin
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    compare_result($sformatf("t%0d.result", idx), got);
                end else begin
                    check($sformatf("t%0d.unexpected_done@%0d", idx, k), 32'(done), 32'd0);
                end
            end
            if (k == v.repulse) start = 1'b1;
            if (k == v.abort_at) abort = 1'b1;
            if (k == v.rst_at) begin
                rst_n = 1'b0;
                #1 check_all_zero($sformatf("t%0d.async_rst", idx));
            end
            if (v.rst_at > 0 && k == v.rst_at + 2) rst_n = 1'b1;
        end
        if (v.has_done) begin
            check($sformatf("t%0d.done_seen", idx), 32'(sb.size()), 32'd0);
            while (sb.size() > 0) got = sb.pop_front();
        end else begin
            compare_result($sformatf("t%0d.final", idx), v);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem_q = 8'h00;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;

        //          fault rep abt rst done pass fail err faddr fexp   fact
        tbl[0] = '{0,   0,  0,  0,  1'b1, 1'b1, 1'b0, 0,  0, 8'h00, 8'h00};
        tbl[1] = '{1,   0,  0,  0,  1'b1, 1'b0, 1'b1, 1,  5, 8'hAF, 8'hAE};
        tbl[2] = '{2,   0,  0,  0,  1'b1, 1'b0, 1'b1, 32, 0, 8'h55, 8'h45};
        tbl[3] = '{0,   50, 0,  0,  1'b1, 1'b1, 1'b0, 0,  0, 8'h00, 8'h00};
        tbl[4] = '{0,   0,  40, 0,  1'b0, 1'b0, 1'b0, 0,  0, 8'h00, 8'h00};
        tbl[5] = '{0,   0,  0,  70, 1'b0, 1'b0, 1'b0, 0,  0, 8'h00, 8'h00};
        tbl[6] = '{0,   0,  0,  0,  1'b1, 1'b1, 1'b0, 0,  0, 8'h00, 8'h00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_write", 32'(write), 32'd0);

        for (int t = 0; t < 7; t++) run_test(t, tbl[t]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
